// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} arb_state_e;
  localparam int DIV_WIDTH = 16;
  localparam logic [DIV_WIDTH-1:0] CLK_DIV_RST = 16'd1;
endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping.
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               vld_o
);
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      logic [IW-1:0] j;
      j = IW'((int'(ptr_i) + k) % NUM_REQ);
      if (!vld_o && req_i[j]) begin
        vld_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end
endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_tx_i,
  input  logic [NUM_REQ-1:0]                   req_cpol_i,
  input  logic [NUM_REQ-1:0]                   req_cpha_i,
  input  logic [NUM_REQ-1:0][DIV_WIDTH-1:0]    req_clk_div_i,
  output logic [NUM_REQ-1:0]                   gnt_o,
  output logic [NUM_REQ-1:0]                   ack_o,
  output logic                                 err_o,
  output logic [DATA_WIDTH-1:0]                rx_data_o,
  output logic [NUM_REQ-1:0]                   cs_sel_o,
  output logic                                 m_start_o,
  output logic [DATA_WIDTH-1:0]                m_tx_byte_o,
  output logic                                 m_cpol_o,
  output logic                                 m_cpha_o,
  output logic [DIV_WIDTH-1:0]                 m_clk_div_o,
  input  logic                                 m_busy_i,
  input  logic                                 m_done_i,
  input  logic [DATA_WIDTH-1:0]                m_rx_byte_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  arb_state_e                state_q, state_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic [NUM_REQ-1:0]        gnt_q, gnt_d, ack_q, ack_d;
  logic [DATA_WIDTH-1:0]     rx_q, rx_d, mtx_q, mtx_d;
  logic                      mpol_q, mpol_d, mpha_q, mpha_d;
  logic [DIV_WIDTH-1:0]      mdiv_q, mdiv_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic [NUM_REQ-1:0]        pick_gnt;
  logic [IW-1:0]             pick_idx;
  logic                      pick_vld;

  spi_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rx_d    = rx_q;
    mtx_d   = mtx_q;
    mpol_d  = mpol_q;
    mpha_d  = mpha_q;
    mdiv_d  = mdiv_q;
    gap_d   = gap_q;
`ifdef SPI_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: if (pick_vld && !m_busy_i) begin
        // Config is snapshotted here so later requester changes cannot leak in.
        gnt_d   = pick_gnt;
        ptr_d   = pick_idx;
        mtx_d   = req_tx_i[pick_idx];
        mpol_d  = req_cpol_i[pick_idx];
        mpha_d  = req_cpha_i[pick_idx];
        mdiv_d  = req_clk_div_i[pick_idx];
        state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: if (m_done_i) begin
        rx_d    = m_rx_byte_i;
        ack_d   = gnt_q;
        gnt_d   = '0;
        gap_d   = '0;
        state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end
`ifdef SPI_ARB_TIMEOUT_EN
      else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
        ack_d   = gnt_q;
        err_d   = 1'b1;
        gnt_d   = '0;
        gap_d   = '0;
        state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      end else begin
        wd_d    = wd_q + 1'b1;
      end
`endif
      S_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      rx_q    <= '0;
      mtx_q   <= '0;
      mpol_q  <= 1'b0;
      mpha_q  <= 1'b0;
      mdiv_q  <= CLK_DIV_RST;
      gap_q   <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rx_q    <= rx_d;
      mtx_q   <= mtx_d;
      mpol_q  <= mpol_d;
      mpha_q  <= mpha_d;
      mdiv_q  <= mdiv_d;
      gap_q   <= gap_d;
`ifdef SPI_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign cs_sel_o    = gnt_q;
  assign ack_o       = ack_q;
  assign rx_data_o   = rx_q;
  assign m_start_o   = (state_q == S_LAUNCH);
  assign m_tx_byte_o = mtx_q;
  assign m_cpol_o    = mpol_q;
  assign m_cpha_o    = mpha_q;
  assign m_clk_div_o = mdiv_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a loopback spi_master model.
module tb_spi_arbiter;
  localparam int N = 4, DW = 8, GAP = 2, TMO = 100;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req, cpol, cpha;
  logic [N-1:0][DW-1:0] req_tx;
  logic [N-1:0][15:0] div;
  logic [N-1:0]       gnt, ack, cs_sel;
  logic               err, m_start, m_cpol, m_cpha, m_busy, m_done;
  logic [DW-1:0]      rx_data, m_tx_byte, m_rx_byte;
  logic [15:0]        m_clk_div;

  int n_chk = 0, n_err = 0, cyc = 0, start_cnt = 0;
  int s_cyc, a_cyc, snap;
  bit slv_mute = 0;

  spi_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_tx_i(req_tx), .req_cpol_i(cpol),
    .req_cpha_i(cpha), .req_clk_div_i(div), .gnt_o(gnt), .ack_o(ack), .err_o(err),
    .rx_data_o(rx_data), .cs_sel_o(cs_sel), .m_start_o(m_start), .m_tx_byte_o(m_tx_byte),
    .m_cpol_o(m_cpol), .m_cpha_o(m_cpha), .m_clk_div_o(m_clk_div), .m_busy_i(m_busy),
    .m_done_i(m_done), .m_rx_byte_i(m_rx_byte)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  // Loopback slave: busy for 2+clk_div cycles after m_start, then one-cycle done.
  initial begin
    int cnt = 0;
    logic [DW-1:0] byt = '0;
    m_busy = 0; m_done = 0; m_rx_byte = '0;
    forever begin
      @(posedge clk); #1;
      m_done = 0;
      if (!rst_n) begin
        cnt = 0; m_busy = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin m_done = 1; m_busy = 0; m_rx_byte = byt; end
      end else if (m_start && !slv_mute) begin
        m_busy = 1; byt = m_tx_byte; cnt = 2 + int'(m_clk_div);
      end
    end
  end

  // Config seen at m_start must still be present at m_done.
  initial begin
    logic [31:0] cfg = '0;
    bit inflight = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) inflight = 0;
      if (m_start) begin
        start_cnt++;
        chk("start_onehot", 32'($onehot(gnt)), 1);
        chk("cs_eq_gnt", 32'(cs_sel), 32'(gnt));
        cfg = {6'd0, m_tx_byte, m_cpol, m_cpha, m_clk_div};
        inflight = 1;
      end
      if (m_done && inflight) begin
        chk("m_cfg_stable", {6'd0, m_tx_byte, m_cpol, m_cpha, m_clk_div}, cfg);
        inflight = 0;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "bench hang");
  end

  task automatic wait_start();
    int n = 0;
    do begin @(negedge clk); n++; end while (!m_start && n < 200);
    chk("start_seen", 32'(m_start), 1);
    s_cyc = cyc;
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin @(negedge clk); n++; end while (ack == '0 && n < 200);
    chk("ack_seen", 32'(ack != '0), 1);
    a_cyc = cyc;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    rst_n = 0; req = '0; cpol = '0; cpha = '0;
    req_tx = '0;
    for (int i = 0; i < N; i++) div[i] = 16'd1;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cs", 32'(cs_sel), 0);
    chk("rst_start", 32'(m_start), 0);
    chk("rst_rx", 32'(rx_data), 0);
    chk("rst_mcfg", {15'd0, m_tx_byte, m_cpol, m_cpha}, 0);
    chk("rst_div", 32'(m_clk_div), 1);
    rst_n = 1;
    @(negedge clk);

    // Single requester, one-cycle grant latency, loopback data.
    req_tx[0] = 8'hA5; req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_start", 32'(m_start), 1);
    wait_ack();
    chk("t1_ack", 32'(ack), 32'h1);
    chk("t1_rx", 32'(rx_data), 32'hA5);
    chk("t1_gnt_clr", 32'(gnt), 0);
    chk("t1_err", 32'(err), 0);
    req = '0;
    @(negedge clk);
    chk("t1_ack_pulse", 32'(ack), 0);
    repeat (6) @(negedge clk);
    chk("t1_one_start", 32'(start_cnt), 1);

    // All requesting: 0,1,2,3,0 with GAP cycles plus one IDLE between.
    do_reset();
    req_tx = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start();
      chk("rr_gnt", 32'(gnt), 32'(1 << exp_ord[k]));
      if (k > 0) chk("rr_spacing", 32'(s_cyc - a_cyc), GAP + 1);
      wait_ack();
      chk("rr_ack", 32'(ack), 32'(1 << exp_ord[k]));
      chk("rr_rx", 32'(rx_data), 32'(8'h11 * (exp_ord[k] + 1)));
    end
    req = '0;
    repeat (4) @(negedge clk);

    // Per-owner SPI mode and divisor.
    cpol[2] = 1; cpha[2] = 1; div[2] = 16'd4;
    req = 4'b0110;
    wait_start();
    chk("mode_gnt1", 32'(gnt), 32'h2);
    chk("mode_cfg1", {m_cpol, m_cpha, m_clk_div}, {2'b00, 16'd1});
    wait_ack();
    req = 4'b0100;
    wait_start();
    chk("mode_gnt2", 32'(gnt), 32'h4);
    chk("mode_cfg2", {m_cpol, m_cpha, m_clk_div}, {2'b11, 16'd4});
    wait_ack();
    chk("mode_ack2", 32'(ack), 32'h4);
    req = '0;
    repeat (4) @(negedge clk);

    // Drop req and change config after grant: transfer still completes.
    req_tx[1] = 8'h3C; req = 4'b0010;
    wait_start();
    @(negedge clk);
    req = '0; req_tx[1] = 8'hFF; cpol[1] = 1; div[1] = 16'd9;
    wait_ack();
    chk("drop_ack", 32'(ack), 32'h2);
    chk("drop_rx", 32'(rx_data), 32'h3C);
    chk("drop_mcfg", {m_tx_byte, m_cpol, m_clk_div}, {8'h3C, 1'b0, 16'd1});

    // Request raised only during GAP is ignored; pointer stays at 1.
    snap = start_cnt;
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    repeat (8) @(negedge clk);
    chk("gap_ignored", 32'(start_cnt), 32'(snap));
    req = 4'b0101;
    wait_start();
    chk("ptr_kept", 32'(gnt), 32'h4);
    wait_ack();
    req = '0;
    cpol[1] = 0; div[1] = 16'd1;
    repeat (4) @(negedge clk);

    // Reset during WAIT: grant drops immediately, no ack afterwards.
    req = 4'b0010;
    wait_start();
    @(negedge clk);
    snap = n_err;
    rst_n = 0;
    #1;
    chk("rstw_gnt", 32'(gnt), 0);
    chk("rstw_cs", 32'(cs_sel), 0);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    begin
      int acks = 0;
      repeat (10) begin @(negedge clk); if (ack != '0) acks++; end
      chk("rstw_no_ack", 32'(acks), 0);
    end
    req = 4'b1000;
    wait_start();
    chk("rstw_regrant", 32'(gnt), 32'h8);
    wait_ack();
    chk("rstw_ack", 32'(ack), 32'h8);
    chk("rstw_rx", 32'(rx_data), 32'h44);
    req = '0;
    repeat (4) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
    // Silent master: ack+err after TMO WAIT cycles, rx_data unchanged.
    slv_mute = 1;
    req = 4'b0001;
    wait_start();
    wait_ack();
    chk("tmo_lat", 32'(a_cyc - s_cyc), TMO + 1);
    chk("tmo_ack", 32'(ack), 32'h1);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_rx", 32'(rx_data), 32'h44);
    req = '0;
    @(negedge clk);
    chk("tmo_err_pulse", 32'(err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one spi_master (2..8).
REQ-002 Parameter DATA_WIDTH, default 8: transfer width; SHALL match the attached spi_master.
REQ-003 Parameter GAP_CYCLES, default 2: idle clk cycles between transfers (0 legal).
REQ-004 Parameter TIMEOUT_CYCLES, default 65535: watchdog limit, used only under SPI_ARB_TIMEOUT_EN.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  NUM_REQ  per-requester transfer request, level, held until ack.
REQ-008 req_tx  input  NUM_REQ*DATA_WIDTH  per-requester transmit byte, slice i = requester i.
REQ-009 req_cpol, req_cpha  input  NUM_REQ each  per-requester SPI mode.
REQ-010 req_clk_div  input  NUM_REQ*16  per-requester half-SCLK divisor.
REQ-011 gnt  output  NUM_REQ  one-hot owner of the master; zero when none.
REQ-012 ack  output  NUM_REQ  one-cycle completion pulse to the owner.
REQ-013 err  output  1  one-cycle pulse coincident with ack when the transfer timed out.
REQ-014 rx_data  output  DATA_WIDTH  received byte, valid in the ack cycle, held until next ack.
REQ-015 cs_sel  output  NUM_REQ  one-hot slave-select enable (equals gnt), for external ss_n gating.
REQ-016 m_start  output  1  one-cycle start to spi_master.
REQ-017 m_tx_byte, m_cpol, m_cpha, m_clk_div  output  DATA_WIDTH/1/1/16  registered config to spi_master, stable from m_start to m_done.
REQ-018 m_busy, m_done  input  1 each; m_rx_byte  input  DATA_WIDTH  from spi_master.

Function
REQ-019 FSM states IDLE, LAUNCH, WAIT, GAP; reset state IDLE.
REQ-020 IDLE: if any req and m_busy low, pick winner round-robin, latch its config into m_* registers, set gnt, go LAUNCH next cycle; else stay.
REQ-021 Round-robin: search starts at last winner +1, wraps at NUM_REQ-1 to 0; last-winner pointer resets to NUM_REQ-1 so requester 0 wins first.
REQ-022 LAUNCH: m_start=1 for exactly this cycle; go WAIT.
REQ-023 Latency: req sampled in IDLE at cycle t -> gnt and m_start high at t+1.
REQ-024 WAIT: on m_done, capture m_rx_byte into rx_data, pulse ack[winner] next cycle, clear gnt/cs_sel that same cycle, go GAP (or IDLE if GAP_CYCLES=0).
REQ-025 GAP: count GAP_CYCLES cycles, then IDLE; requests ignored during GAP.
REQ-026 req deassert after grant SHALL NOT abort; transfer completes and ack still issues.
REQ-027 req deassert before sampling in IDLE: no grant, pointer unchanged.
REQ-028 m_done outside WAIT SHALL be ignored; m_start SHALL never assert in any state but LAUNCH.
REQ-029 Requester config changes after grant SHALL NOT affect m_* outputs.

Reset
REQ-030 rst_n low: state IDLE, gnt/ack/cs_sel/err/m_start=0, rx_data=0, m_tx_byte=0, m_cpol=0, m_cpha=0, m_clk_div=1, pointer=NUM_REQ-1, counters 0.
REQ-031 Reset mid-transfer SHALL drop gnt immediately, with no ack; spi_master reset is the integrator's responsibility.

Configuration
REQ-032 Macro SPI_ARB_TIMEOUT_EN defined: WAIT counter increments each cycle; reaching TIMEOUT_CYCLES without m_done -> ack[winner] and err pulse, rx_data unchanged, go GAP.
REQ-033 SPI_ARB_TIMEOUT_EN undefined: no counter, err tied 0, WAIT waits indefinitely.

Structure
REQ-034 Shared package spi_arb_pkg: FSM state encodings, default clk_div constant, DIV_WIDTH=16.
REQ-035 Sub-module spi_rr_pick: combinational round-robin picker (req, pointer -> one-hot grant, valid).

Verification
REQ-036 Single req[0], tx 0xA5, slave loopback -> m_start at t+1, ack[0] once, rx_data=0xA5.
REQ-037 req=4'b1111 held continuously -> grants in order 0,1,2,3,0; each separated by GAP_CYCLES=2 idle cycles.
REQ-038 req[2] mode 3 clk_div 4, req[1] mode 0 clk_div 1 -> m_cpol/m_cpha/m_clk_div match owner for each transfer, stable through m_done.
REQ-039 req[1] dropped in WAIT; req_tx[1] changed after grant -> transfer completes with original byte, ack[1] issued.
REQ-040 rst_n low during WAIT -> gnt=0 same cycle, no ack, FSM IDLE; next req[3] granted normally.
REQ-041 SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, m_done held low -> ack and err pulse at cycle 100 of WAIT, rx_data unchanged.
